ex_muldiv_unit: RTL

Parametrised iterative multiply/divide unit for the EX stage, with architectural HI/LO registers. It replaces the single-cycle combinational multiplier path. Signed and unsigned multiply and divide run one bit per cycle; MTHI/MTLO writes complete in one cycle. `busy` stalls the pipeline, and `flush` aborts an in-flight operation.

---
 rtl/ex_muldiv_unit_if.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The EX stage drives through the master modport; the unit answers through the slave modport.
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in the FIX cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input logic             clk,
    input logic             rst_n,
    ex_muldiv_unit_if.slave bus
);

    localparam logic [2:0]       OP_DIV   = 3'b010;
    localparam logic [2:0]       OP_MTHI  = 3'b100;
    localparam logic [2:0]       OP_MTLO  = 3'b101;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return (sgn && (s < 0)) ? WIDTH'(-s) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic             start_ok;
    logic             accept;
    logic             op_sgn;
    logic             op_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // A held start is taken in IDLE or on the completing FIX edge (back-to-back issue).
    assign start_ok = bus.start & ~bus.flush;
    assign accept   = start_ok & ~bus.op[2] & ((state == S_IDLE) | (state == S_FIX));
    assign op_sgn   = ~bus.op[0];
    assign op_div   = bus.op[1];
    assign a_mag    = abs_val(bus.a, op_sgn);
    assign b_mag    = abs_val(bus.b, op_sgn);

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next;

    assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign mul_acc_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: the shifted partial remainder carries one guard bit.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_acc_next;

    assign div_shift    = {rem, acc[WIDTH-1]};
    assign div_ge       = div_shift >= {1'b0, mcand};
    assign div_diff     = div_shift[WIDTH-1:0] - mcand;
    assign rem_next     = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod = neg_2w(acc, neg_q);
        quo  = neg_w(acc[WIDTH-1:0], neg_q);
        rmd  = neg_w(rem, neg_r);
        if (div_zero) begin
            quo = '1;
        end
        if (div_ovf) begin
            quo = MOST_NEG;
            rmd = '0;
        end
        fix_hi = is_div ? rmd : prod[2*WIDTH-1:WIDTH];
        fix_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            rem      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok && (bus.op == OP_MTHI)) begin
                        hi_q <= bus.a;
                    end else if (start_ok && (bus.op == OP_MTLO)) begin
                        lo_q <= bus.a;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= is_div ? div_acc_next : mul_acc_next;
                        if (is_div) begin
                            rem <= rem_next;
                        end
                        if (cnt == CNT_LAST) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Operand capture overrides the state update above.
            if (accept) begin
                state    <= S_RUN;
                cnt      <= '0;
                is_div   <= op_div;
                neg_q    <= op_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= op_sgn & bus.a[WIDTH-1];
                div_zero <= op_div & (bus.b == '0);
                div_ovf  <= (bus.op == OP_DIV) & (bus.a == MOST_NEG) & (bus.b == '1);
                mcand    <= op_div ? b_mag : a_mag;
                acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                rem      <= '0;
            end
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
